trouble_scan_scheduler: RTL and testbench
=========================================

Name: trouble_scan_scheduler

Overview:
- Periodically sequences the per-channel trouble (self-test) detection over the four vibration-sensor channels.
- Arms one channel's detect enable at a time and waits for the detector's completion strobe, with a timeout.
- Latches per-channel trouble and timeout status for the incident path.
- Sits between the K64 control word (scan enable/force/mask bits) and the trouble detector, replacing the static all-channel enable.

Parameters:
- NUM_CH, 4, number of channels scanned; the channel index is 2 bits wide.
- PERIOD_CYC, 50_000_000, cycles between scan starts (1 s at 50 MHz).
- TIMEOUT_CYC, 1_000_000, maximum cycles to wait for detect_over per channel.
- GAP_CYC, 16, cycles with all enables low between consecutive channels.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- scan_enable  in  1  level; 1 = periodic scanning allowed (K64 control bit).
- scan_force  in  1  one-cycle pulse; start a scan immediately.
- ch_mask  in  NUM_CH  1 = channel included in the scan; sampled at scan start.
- trouble_in  in  NUM_CH  per-channel trouble result from the detector; valid when detect_over rises.
- detect_over  in  1  detector completion; level or pulse, only its rising edge is used.
- ch_detect_en  out  NUM_CH  one-hot (or zero) enable to the detector.
- scan_busy  out  1  high from scan start until DONE or abort.
- scan_done  out  1  one-cycle pulse when a scan completes.
- trouble_status  out  NUM_CH  latched per-channel trouble flag.
- timeout_status  out  NUM_CH  latched per-channel timeout flag.
- scan_count  out  8  completed-scan counter; wraps 255 -> 0.

Behaviour:
- Reset (async, rst=0):
  - state = IDLE; every output = 0.
  - Period counter, timeout counter, channel index and edge register = 0.
- FSM states and transitions:
  - IDLE: if scan_enable=1, load period counter with PERIOD_CYC-1 and go to WAIT_PERIOD.
  - WAIT_PERIOD: decrement the period counter. Start a scan when the counter reaches 0, or when scan_force=1 in any WAIT_PERIOD cycle.
  - Scan start:
    - Sample ch_mask into mask_r.
    - Clear trouble_status and timeout_status bits for masked-out channels; unmasked bits keep their old values until re-measured.
    - Set scan_busy=1.
    - idx = lowest set bit of mask_r, then go to ARM. If mask_r is 0, go directly to DONE.
  - ARM (1 cycle): ch_detect_en = one-hot(idx); load timeout counter with TIMEOUT_CYC-1; go to WAIT_DONE. ch_detect_en is high the cycle after the start decision (latency 1).
  - WAIT_DONE: hold ch_detect_en; decrement the timeout counter.
    - On a detect_over rising edge (detect_over=1 and the previous sample =0): trouble_status[idx] <= trouble_in[idx]; timeout_status[idx] <= 0; go to GAP.
    - Timeout counter at 0 with no edge: trouble_status[idx] <= 1; timeout_status[idx] <= 1; go to GAP.
    - Edge and timeout in the same cycle: the edge wins.
  - GAP: ch_detect_en = 0 for GAP_CYC cycles. Then go to ARM with the next higher set bit of mask_r, or to DONE if there is none.
  - DONE (1 cycle): scan_done=1; scan_count += 1 (mod 256); scan_busy=0. Go to WAIT_PERIOD with the period reloaded if scan_enable=1, else to IDLE.
- Edge detection:
  - The edge register samples detect_over every cycle in every state.
  - A detect_over that is already high when ARM is entered is not a completion.
- Abort: scan_enable=0 in any state other than IDLE.
  - Next cycle: ch_detect_en=0, scan_busy=0, state IDLE.
  - No scan_done pulse; scan_count and all status bits keep their current values.
- scan_force:
  - Ignored in IDLE, ARM, WAIT_DONE, GAP and DONE.
  - Ignored when scan_enable=0.
- Invariant: ch_detect_en has at most one bit set in every cycle.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit. Counters saturate at 0, never underflow.

Decomposition:
- Shared package signal_detect_pkg holds:
  - the state typedef (IDLE, WAIT_PERIOD, ARM, WAIT_DONE, GAP, DONE);
  - NUM_CH;
  - default PERIOD_CYC, TIMEOUT_CYC and GAP_CYC constants.
- One sub-module, ch_next_sel: combinational priority finder returning the lowest set bit of mask_r at or above a start index, plus a none-left flag. Used both at scan start and after each GAP.

Test Plan:
(bench parameters: PERIOD_CYC=100, TIMEOUT_CYC=50, GAP_CYC=4)
1. All-channel scan:
   - Stimulus: scan_enable=1, ch_mask=4'b1111, detect_over pulsed 10 cycles after each ARM, trouble_in=4'b0100.
   - Required response: ch_detect_en sequence 0001, 0010, 0100, 1000; trouble_status=4'b0100; timeout_status=0; one scan_done; scan_count=1.
2. Timeout:
   - Stimulus: detect_over never rises for ch1.
   - Required response: ch_detect_en=0010 held exactly 50 WAIT_DONE cycles; then trouble_status[1]=1 and timeout_status=4'b0010; scan proceeds to ch2.
3. Mask:
   - Stimulus: ch_mask=4'b1010, with old status 4'b1111 preloaded.
   - Required response: only en[1] and en[3] ever asserted; status bits 0 and 2 read 0 after scan start.
   - Sub-case ch_mask=0: scan_done within 2 cycles of start and no enable ever asserted.
4. Abort:
   - Stimulus: drop scan_enable while ch_detect_en=0100.
   - Required response: next cycle en=0 and busy=0; no scan_done; scan_count unchanged.
5. Force, stale level and tie:
   - scan_force at period count 70: ch_detect_en=0001 within 2 cycles.
   - scan_force during WAIT_DONE: no effect.
   - detect_over held high across ARM: no completion (timeout results).
   - detect_over edge on the timeout cycle: timeout_status bit = 0.
6. Reset:
   - rst low mid-WAIT_DONE: all outputs 0 immediately (asynchronous).
   - After release with scan_enable=1: first ARM occurs 100 cycles later.

Source files
------------

// File: rtl/signal_detect_pkg.sv
// Shared definitions for the trouble-scan scheduler.
//   NUM_CH / IDX_W       : channel count and channel index width
//   DEF_*_CYC            : default period, per-channel timeout and inter-channel gap
//   state_t              : scheduler FSM states
//   cnt_w()              : counter width for a cycle count (minimum 1 bit)
//   onehot()             : channel index to enable vector
package signal_detect_pkg;

    localparam int NUM_CH          = 4;
    localparam int IDX_W           = 2;
    localparam int DEF_PERIOD_CYC  = 50_000_000;
    localparam int DEF_TIMEOUT_CYC = 1_000_000;
    localparam int DEF_GAP_CYC     = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PERIOD,
        ARM,
        WAIT_DONE,
        GAP,
        DONE
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [NUM_CH-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_CH-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/ch_next_sel.sv
// Priority finder: lowest set bit of mask at or above start.
//   mask  : candidate channels
//   start : first index allowed; one bit wider than idx so "past the last
//           channel" is representable
//   idx   : selected channel (0 when none)
//   none  : no set bit at or above start
module ch_next_sel
    import signal_detect_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [IDX_W:0]    start,
    output logic [IDX_W-1:0]  idx,
    output logic              none
);

    // Scan from the top down so the lowest qualifying bit is written last.
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(start))) begin
                idx  = IDX_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/trouble_scan_scheduler.sv
// Periodic trouble-detect scan sequencer. Arms one channel's detect enable at
// a time, waits for a detect_over rising edge (or a timeout), latches per-
// channel trouble/timeout status, and repeats every PERIOD_CYC cycles.
//   clk, rst              : clock, asynchronous active-low reset
//   scan_enable           : level, periodic scanning allowed; low aborts
//   scan_force            : pulse, start a scan now (WAIT_PERIOD only)
//   ch_mask               : channels included, sampled at scan start
//   trouble_in            : detector result, valid on detect_over rise
//   detect_over           : detector completion (rising edge used)
//   ch_detect_en          : one-hot (or zero) detector enable
//   scan_busy, scan_done  : scan in progress / one-cycle completion pulse
//   trouble_status        : latched trouble per channel
//   timeout_status        : latched timeout per channel
//   scan_count            : completed scans, wraps at 256
module trouble_scan_scheduler
    import signal_detect_pkg::*;
#(
    parameter int PERIOD_CYC  = DEF_PERIOD_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int GAP_CYC     = DEF_GAP_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_enable,
    input  logic              scan_force,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [NUM_CH-1:0] trouble_in,
    input  logic              detect_over,
    output logic [NUM_CH-1:0] ch_detect_en,
    output logic              scan_busy,
    output logic              scan_done,
    output logic [NUM_CH-1:0] trouble_status,
    output logic [NUM_CH-1:0] timeout_status,
    output logic [7:0]        scan_count
);

    localparam int PW = cnt_w(PERIOD_CYC);
    localparam int TW = cnt_w(TIMEOUT_CYC);
    localparam int GW = cnt_w(GAP_CYC);
    localparam logic [PW-1:0] PERIOD_LOAD  = PW'(PERIOD_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LOAD     = GW'(GAP_CYC - 1);

    state_t            state;
    logic [PW-1:0]     period_cnt;
    logic [TW-1:0]     tmo_cnt;
    logic [GW-1:0]     gap_cnt;
    logic [IDX_W-1:0]  idx;
    logic [NUM_CH-1:0] mask_r;
    logic              det_q;

    logic              det_rise;
    logic [NUM_CH-1:0] sel_mask;
    logic [IDX_W:0]    sel_start;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_none;

    assign det_rise = detect_over & ~det_q;

    // At scan start mask_r is not loaded yet, so search the live ch_mask from
    // channel 0; after a gap, search mask_r above the channel just finished.
    assign sel_mask  = (state == WAIT_PERIOD) ? ch_mask : mask_r;
    assign sel_start = (state == WAIT_PERIOD) ? '0 : ({1'b0, idx} + (IDX_W+1)'(1));

    ch_next_sel u_sel (
        .mask  (sel_mask),
        .start (sel_start),
        .idx   (sel_idx),
        .none  (sel_none)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            period_cnt     <= '0;
            tmo_cnt        <= '0;
            gap_cnt        <= '0;
            idx            <= '0;
            mask_r         <= '0;
            det_q          <= 1'b0;
            ch_detect_en   <= '0;
            scan_busy      <= 1'b0;
            scan_done      <= 1'b0;
            trouble_status <= '0;
            timeout_status <= '0;
            scan_count     <= '0;
        end else begin
            det_q     <= detect_over;
            scan_done <= 1'b0;
            if (state != IDLE && !scan_enable) begin
                // Abort: drop the enable, keep status and count untouched.
                state        <= IDLE;
                ch_detect_en <= '0;
                scan_busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (scan_enable) begin
                            period_cnt <= PERIOD_LOAD;
                            state      <= WAIT_PERIOD;
                        end
                    end
                    WAIT_PERIOD: begin
                        if (period_cnt == '0 || scan_force) begin
                            mask_r         <= ch_mask;
                            trouble_status <= trouble_status & ch_mask;
                            timeout_status <= timeout_status & ch_mask;
                            if (sel_none) begin
                                scan_done  <= 1'b1;
                                scan_count <= scan_count + 8'd1;
                                scan_busy  <= 1'b0;
                                state      <= DONE;
                            end else begin
                                idx          <= sel_idx;
                                ch_detect_en <= onehot(sel_idx);
                                scan_busy    <= 1'b1;
                                state        <= ARM;
                            end
                        end else begin
                            period_cnt <= period_cnt - PW'(1);
                        end
                    end
                    ARM: begin
                        tmo_cnt <= TIMEOUT_LOAD;
                        state   <= WAIT_DONE;
                    end
                    WAIT_DONE: begin
                        // The edge is checked first so it wins over a
                        // same-cycle timeout.
                        if (det_rise) begin
                            trouble_status[idx] <= trouble_in[idx];
                            timeout_status[idx] <= 1'b0;
                            ch_detect_en        <= '0;
                            gap_cnt             <= GAP_LOAD;
                            state               <= GAP;
                        end else if (tmo_cnt == '0) begin
                            trouble_status[idx] <= 1'b1;
                            timeout_status[idx] <= 1'b1;
                            ch_detect_en        <= '0;
                            gap_cnt             <= GAP_LOAD;
                            state               <= GAP;
                        end else begin
                            tmo_cnt <= tmo_cnt - TW'(1);
                        end
                    end
                    GAP: begin
                        if (gap_cnt != '0) begin
                            gap_cnt <= gap_cnt - GW'(1);
                        end else if (sel_none) begin
                            scan_done  <= 1'b1;
                            scan_count <= scan_count + 8'd1;
                            scan_busy  <= 1'b0;
                            state      <= DONE;
                        end else begin
                            idx          <= sel_idx;
                            ch_detect_en <= onehot(sel_idx);
                            state        <= ARM;
                        end
                    end
                    DONE: begin
                        // scan_enable is known high here; low was taken as abort.
                        period_cnt <= PERIOD_LOAD;
                        state      <= WAIT_PERIOD;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trouble_scan_scheduler.sv
// Directed bench for trouble_scan_scheduler with PERIOD_CYC=100,
// TIMEOUT_CYC=50, GAP_CYC=4. Outputs are sampled on the falling clock edge.
module tb_trouble_scan_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scan_enable = 1'b0;
    logic       scan_force = 1'b0;
    logic [3:0] ch_mask = 4'b0;
    logic [3:0] trouble_in = 4'b0;
    logic       detect_over;
    logic [3:0] ch_detect_en, trouble_status, timeout_status;
    logic       scan_busy, scan_done;
    logic [7:0] scan_count;

    int vectors = 0;
    int miscompares = 0;

    // detector model controls
    bit         resp_on = 1'b0;
    logic [3:0] resp_skip = 4'b0;
    int         det_delay = 10;
    logic       det_hold = 1'b0;
    logic [3:0] resp_prev = 4'b0;
    int         resp_cnt = 0;
    logic       resp_pulse;

    // monitor state
    logic [3:0] mon_prev = 4'b0;
    logic [3:0] en_seq[$];
    int         done_cnt = 0;
    bit         onehot_bad = 1'b0;

    trouble_scan_scheduler #(
        .PERIOD_CYC  (100),
        .TIMEOUT_CYC (50),
        .GAP_CYC     (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .scan_enable    (scan_enable),
        .scan_force     (scan_force),
        .ch_mask        (ch_mask),
        .trouble_in     (trouble_in),
        .detect_over    (detect_over),
        .ch_detect_en   (ch_detect_en),
        .scan_busy      (scan_busy),
        .scan_done      (scan_done),
        .trouble_status (trouble_status),
        .timeout_status (timeout_status),
        .scan_count     (scan_count)
    );

    always #5 clk = ~clk;

    // Detector: one-cycle detect_over pulse det_delay cycles after an enable
    // rises, unless the armed channel is in resp_skip; det_hold forces it high.
    initial begin
        detect_over = 1'b0;
        forever begin
            @(negedge clk);
            resp_pulse = 1'b0;
            if (ch_detect_en != 4'b0 && resp_prev == 4'b0 && resp_on &&
                (ch_detect_en & resp_skip) == 4'b0)
                resp_cnt = det_delay;
            else if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) resp_pulse = 1'b1;
            end
            detect_over = det_hold | resp_pulse;
            resp_prev   = ch_detect_en;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (ch_detect_en != 4'b0 && ch_detect_en != mon_prev) en_seq.push_back(ch_detect_en);
            if (scan_done === 1'b1) done_cnt++;
            if ($countones(ch_detect_en) > 1) onehot_bad = 1'b1;
            mon_prev = ch_detect_en;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_en(input logic [3:0] v, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (ch_detect_en === v) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (scan_done === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic go_idle();
        scan_enable = 1'b0;
        scan_force  = 1'b0;
        cyc(3);
    endtask

    // Enable, let the FSM reach WAIT_PERIOD, then force a start; returns on
    // the falling edge just after the start decision.
    task automatic force_start();
        scan_enable = 1'b1;
        cyc(2);
        scan_force = 1'b1;
        cyc(1);
        scan_force = 1'b0;
    endtask

    function automatic logic [15:0] seq_from(input int b);
        logic [15:0] g = 16'h0;
        for (int i = b; i < en_seq.size(); i++) g = {g[11:0], en_seq[i]};
        return g;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        cyc(3);
        vectors++;
        if ({ch_detect_en, scan_busy, scan_done, trouble_status, timeout_status, scan_count} !== 22'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: en=%b busy=%b done=%b tr=%b to=%b cnt=%0d, want all 0",
                     ch_detect_en, scan_busy, scan_done, trouble_status, timeout_status, scan_count);
        end
        rst = 1'b1;
        cyc(2);
    endtask

    task automatic test_all_channel();
        bit ok; int b, d;
        ch_mask = 4'b1111; trouble_in = 4'b0100; resp_on = 1'b1; resp_skip = 4'b0; det_delay = 10;
        b = en_seq.size(); d = done_cnt;
        scan_enable = 1'b1;
        wait_done(1000, ok);
        cyc(2);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL all_done_wait: no scan_done within 1000 cycles"); end
        vectors++;
        if (en_seq.size() != b + 4 || seq_from(b) !== 16'h1248) begin
            miscompares++;
            $display("FAIL all_en_seq: got %h (%0d entries), want 1248 (4 entries)", seq_from(b), en_seq.size() - b);
        end
        vectors++;
        if (trouble_status !== 4'b0100 || timeout_status !== 4'b0000) begin
            miscompares++;
            $display("FAIL all_status: tr=%b to=%b, want 0100 0000", trouble_status, timeout_status);
        end
        vectors++;
        if (done_cnt - d != 1 || scan_count !== 8'd1) begin
            miscompares++;
            $display("FAIL all_done_count: pulses=%0d cnt=%0d, want 1 1", done_cnt - d, scan_count);
        end
        go_idle();
    endtask

    task automatic test_timeout();
        bit ok; int dur;
        ch_mask = 4'b1111; trouble_in = 4'b0000; resp_on = 1'b1; resp_skip = 4'b0010;
        force_start();
        wait_en(4'b0010, 300, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL tmo_arm_wait: ch1 never armed"); end
        dur = 0;
        while (ch_detect_en === 4'b0010 && dur < 200) begin dur++; @(negedge clk); end
        // one ARM cycle plus 50 WAIT_DONE cycles
        vectors++;
        if (dur != 51) begin miscompares++; $display("FAIL tmo_en_len: en=0010 for %0d cycles, want 51", dur); end
        // ch2 still holds its old trouble bit from the previous scan
        vectors++;
        if (trouble_status !== 4'b0110 || timeout_status !== 4'b0010) begin
            miscompares++;
            $display("FAIL tmo_status: tr=%b to=%b, want 0110 0010", trouble_status, timeout_status);
        end
        wait_en(4'b0100, 20, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL tmo_next_ch: got en=%b, want 0100 after gap", ch_detect_en); end
        wait_done(300, ok);
        cyc(1);
        vectors++;
        if (!ok || trouble_status !== 4'b0010 || timeout_status !== 4'b0010 || scan_count !== 8'd2) begin
            miscompares++;
            $display("FAIL tmo_final: done=%b tr=%b to=%b cnt=%0d, want 1 0010 0010 2",
                     ok, trouble_status, timeout_status, scan_count);
        end
        go_idle();
    endtask

    task automatic test_mask();
        bit ok; int b, k;
        // preload: no detector response, every channel times out
        ch_mask = 4'b1111; resp_on = 1'b0; resp_skip = 4'b0;
        force_start();
        wait_done(1000, ok);
        cyc(1);
        vectors++;
        if (!ok || {trouble_status, timeout_status} !== 8'hFF || scan_count !== 8'd3) begin
            miscompares++;
            $display("FAIL mask_preload: done=%b tr=%b to=%b cnt=%0d, want 1 1111 1111 3",
                     ok, trouble_status, timeout_status, scan_count);
        end
        go_idle();
        ch_mask = 4'b1010; trouble_in = 4'b0000; resp_on = 1'b1; det_delay = 10;
        b = en_seq.size();
        force_start();
        vectors++;
        if (trouble_status !== 4'b1010 || timeout_status !== 4'b1010) begin
            miscompares++;
            $display("FAIL mask_clear: tr=%b to=%b, want 1010 1010", trouble_status, timeout_status);
        end
        wait_done(500, ok);
        cyc(2);
        vectors++;
        if (!ok || en_seq.size() != b + 2 || seq_from(b) !== 16'h0028) begin
            miscompares++;
            $display("FAIL mask_en_seq: done=%b got %h (%0d entries), want 28 (2 entries)",
                     ok, seq_from(b), en_seq.size() - b);
        end
        vectors++;
        if (trouble_status !== 4'b0000 || timeout_status !== 4'b0000 || scan_count !== 8'd4) begin
            miscompares++;
            $display("FAIL mask_final: tr=%b to=%b cnt=%0d, want 0000 0000 4", trouble_status, timeout_status, scan_count);
        end
        go_idle();
        // empty mask
        ch_mask = 4'b0000;
        b = en_seq.size();
        scan_enable = 1'b1;
        cyc(2);
        scan_force = 1'b1;
        k = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) scan_force = 1'b0;
            if (scan_done === 1'b1) begin k = i; break; end
        end
        cyc(2);
        vectors++;
        if (k < 1 || k > 2 || en_seq.size() != b || scan_count !== 8'd5) begin
            miscompares++;
            $display("FAIL mask_zero: done after %0d cycles, enables=%0d cnt=%0d, want 1..2 0 5",
                     k, en_seq.size() - b, scan_count);
        end
        go_idle();
    endtask

    task automatic test_abort();
        bit ok; int d;
        ch_mask = 4'b1111; trouble_in = 4'b0000; resp_on = 1'b1; resp_skip = 4'b0; det_delay = 10;
        d = done_cnt;
        force_start();
        wait_en(4'b0100, 200, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL abort_arm_wait: ch2 never armed"); end
        scan_enable = 1'b0;
        cyc(1);
        vectors++;
        if (ch_detect_en !== 4'b0 || scan_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_drop: en=%b busy=%b, want 0000 0", ch_detect_en, scan_busy);
        end
        cyc(20);
        vectors++;
        if (done_cnt != d || scan_count !== 8'd5) begin
            miscompares++;
            $display("FAIL abort_count: pulses=%0d cnt=%0d, want 0 5", done_cnt - d, scan_count);
        end
        go_idle();
    endtask

    task automatic test_force_stale_tie();
        bit ok; int k, dur;
        // force at period count 70, then force again inside WAIT_DONE
        ch_mask = 4'b0001; trouble_in = 4'b0001; resp_on = 1'b1; det_delay = 10;
        scan_enable = 1'b1;
        cyc(30);
        scan_force = 1'b1;
        k = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) scan_force = 1'b0;
            if (ch_detect_en === 4'b0001) begin k = i; break; end
        end
        vectors++;
        if (k < 1 || k > 2) begin miscompares++; $display("FAIL force_start: en=0001 after %0d cycles, want 1..2", k); end
        dur = 0;
        while (ch_detect_en === 4'b0001 && dur < 100) begin
            dur++;
            scan_force = (dur == 3);
            @(negedge clk);
        end
        scan_force = 1'b0;
        // ARM cycle plus 10 WAIT_DONE cycles until the pulse is taken
        vectors++;
        if (dur != 11) begin miscompares++; $display("FAIL force_in_wait: en high %0d cycles, want 11", dur); end
        wait_done(50, ok);
        cyc(1);
        vectors++;
        if (!ok || trouble_status !== 4'b0001 || timeout_status !== 4'b0000 || scan_count !== 8'd6) begin
            miscompares++;
            $display("FAIL force_result: done=%b tr=%b to=%b cnt=%0d, want 1 0001 0000 6",
                     ok, trouble_status, timeout_status, scan_count);
        end
        go_idle();
        // detect_over already high across ARM
        resp_on = 1'b0; det_hold = 1'b1; trouble_in = 4'b0000;
        cyc(2);
        force_start();
        wait_done(200, ok);
        cyc(1);
        vectors++;
        if (!ok || trouble_status !== 4'b0001 || timeout_status !== 4'b0001 || scan_count !== 8'd7) begin
            miscompares++;
            $display("FAIL stale_level: done=%b tr=%b to=%b cnt=%0d, want 1 0001 0001 7",
                     ok, trouble_status, timeout_status, scan_count);
        end
        go_idle();
        det_hold = 1'b0;
        // edge arrives on the timeout cycle
        resp_on = 1'b1; det_delay = 50;
        cyc(2);
        force_start();
        wait_done(200, ok);
        cyc(1);
        vectors++;
        if (!ok || trouble_status !== 4'b0000 || timeout_status !== 4'b0000 || scan_count !== 8'd8) begin
            miscompares++;
            $display("FAIL tie_edge_wins: done=%b tr=%b to=%b cnt=%0d, want 1 0000 0000 8",
                     ok, trouble_status, timeout_status, scan_count);
        end
        go_idle();
    endtask

    task automatic test_async_reset();
        bit ok; int k;
        ch_mask = 4'b1111; resp_on = 1'b1; det_delay = 10;
        force_start();
        cyc(3);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({ch_detect_en, scan_busy, scan_done, trouble_status, timeout_status, scan_count} !== 22'h0) begin
            miscompares++;
            $display("FAIL reset_async: en=%b busy=%b done=%b tr=%b to=%b cnt=%0d, want all 0",
                     ch_detect_en, scan_busy, scan_done, trouble_status, timeout_status, scan_count);
        end
        @(negedge clk);
        rst = 1'b1;
        k = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (ch_detect_en === 4'b0001) begin k = i; break; end
        end
        // one IDLE cycle, then 100 WAIT_PERIOD cycles (count 99..0), then ARM
        vectors++;
        if (k != 101) begin miscompares++; $display("FAIL reset_first_arm: first ARM after %0d cycles, want 101", k); end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_all_channel();
        test_timeout();
        test_mask();
        test_abort();
        test_force_stale_tie();
        test_async_reset();
        vectors++;
        if (onehot_bad) begin miscompares++; $display("FAIL onehot_invariant: more than one enable bit seen, want at most one"); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
